// File: rtl/i2s_adc_receiver_pkg.sv
// Shared audio definitions: sample width, channel encoding and the capture FSM states.
// The width default is also used by I2S_Audio and Sin_Generator.
package i2s_adc_receiver_pkg;

  localparam int AUDIO_DATA_WIDTH = 16;

  // adclrck encoding of the two channels
  localparam logic CH_LEFT  = 1'b0;
  localparam logic CH_RIGHT = 1'b1;

  typedef enum logic [1:0] {
    ST_IDLE  = 2'd0,
    ST_LEFT  = 2'd1,
    ST_RIGHT = 2'd2
  } rx_state_t;

endpackage

// File: rtl/i2s_adc_receiver_sync_edge_det.sv
// Multi-flop synchroniser for slow asynchronous lines, with a one-clk pulse on a
// 0->1 transition of bit 0 of the synchronised vector.
module sync_edge_det #(
  parameter int WIDTH       = 1,
  parameter int SYNC_STAGES = 2
) (
  input  logic             clk,
  input  logic             reset_n,
  input  logic [WIDTH-1:0] d,
  output logic [WIDTH-1:0] q,
  output logic             rise
);

  logic [SYNC_STAGES-1:0][WIDTH-1:0] chain;
  logic                              q0_prev;

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      chain   <= '0;
      q0_prev <= 1'b0;
    end else begin
      chain   <= {chain[SYNC_STAGES-2:0], d};
      q0_prev <= chain[SYNC_STAGES-1][0];
    end
  end

  assign q    = chain[SYNC_STAGES-1];
  assign rise = q[0] & ~q0_prev;

endmodule

// File: rtl/i2s_adc_receiver.sv
// WM8731 ADC I2S capture: deserialises adcdat into left/right PCM words in the
// codec master-clock domain and presents each stereo frame on a one-deep register.
module i2s_adc_receiver
  import i2s_adc_receiver_pkg::*;
#(
  parameter int DATA_WIDTH  = AUDIO_DATA_WIDTH,
  parameter int SYNC_STAGES = 2
) (
  input  logic                  clk,
  input  logic                  reset_n,
  input  logic                  bclk,
  input  logic                  adclrck,
  input  logic                  adcdat,
  output logic [DATA_WIDTH-1:0] left_out,
  output logic [DATA_WIDTH-1:0] right_out,
  output logic                  out_valid,
  input  logic                  out_ready,
  output logic                  overrun,
  output logic                  frame_err,
  output rx_state_t             dbg_state
);

  localparam int              CW        = $clog2(DATA_WIDTH + 1);
  localparam logic [CW-1:0]   CNT_FULL  = CW'(DATA_WIDTH);
  localparam logic [CW-1:0]   CNT_LAST  = CW'(DATA_WIDTH - 1);

  logic                  bit_event;
  logic                  bclk_unused_s;
  logic                  lines_rise_unused;
  logic [1:0]            lines_s;
  logic                  lr_s;
  logic                  dat_s;
  logic                  lr_prev;
  logic                  lr_change;
  logic                  commit;
  logic [CW-1:0]         bit_cnt;
  logic [DATA_WIDTH-1:0] left_sr;
  logic [DATA_WIDTH-1:0] right_sr;
  logic [DATA_WIDTH-1:0] right_next;
  rx_state_t             state;

  sync_edge_det #(.WIDTH(1), .SYNC_STAGES(SYNC_STAGES)) u_bclk_sync (
    .clk     (clk),
    .reset_n (reset_n),
    .d       (bclk),
    .q       (bclk_unused_s),
    .rise    (bit_event)
  );

  sync_edge_det #(.WIDTH(2), .SYNC_STAGES(SYNC_STAGES)) u_line_sync (
    .clk     (clk),
    .reset_n (reset_n),
    .d       ({adcdat, adclrck}),
    .q       (lines_s),
    .rise    (lines_rise_unused)
  );

  assign lr_s       = lines_s[0];
  assign dat_s      = lines_s[1];
  assign lr_change  = bit_event && (lr_s != lr_prev);
  assign right_next = {right_sr[DATA_WIDTH-2:0], dat_s};
  // The right LSB is the bit event that fills the last free slot of right_sr.
  assign commit     = bit_event && (state == ST_RIGHT) && !lr_change && (bit_cnt == CNT_LAST);
  assign dbg_state  = state;

  // Output handshake: a pair transfers on every clk where out_valid && out_ready;
  // left_out/right_out never change while out_valid=1 and out_ready=0, and a new
  // frame may replace the pair in the same clk that the consumer takes it.
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      state     <= ST_IDLE;
      bit_cnt   <= '0;
      lr_prev   <= 1'b0;
      left_sr   <= '0;
      right_sr  <= '0;
      left_out  <= '0;
      right_out <= '0;
      out_valid <= 1'b0;
      overrun   <= 1'b0;
      frame_err <= 1'b0;
    end else begin
      overrun   <= 1'b0;
      frame_err <= 1'b0;

      if (commit) begin
        if (!out_valid || out_ready) begin
          left_out  <= left_sr;
          right_out <= right_next;
          out_valid <= 1'b1;
        end else begin
          overrun   <= 1'b1;
        end
      end else if (out_valid && out_ready) begin
        out_valid <= 1'b0;
      end

      if (bit_event) begin
        lr_prev <= lr_s;
        case (state)
          ST_IDLE: begin
            // Only a fall to left starts capture, so frames are always left-aligned.
            if (lr_change && lr_s == CH_LEFT) begin
              state   <= ST_LEFT;
              bit_cnt <= '0;
            end
          end
          ST_LEFT: begin
            if (lr_change) begin
              if (bit_cnt == CNT_FULL) begin
                state   <= ST_RIGHT;
                bit_cnt <= '0;
              end else begin
                frame_err <= 1'b1;
                state     <= ST_IDLE;
              end
            end else if (bit_cnt != CNT_FULL) begin
              left_sr <= {left_sr[DATA_WIDTH-2:0], dat_s};
              bit_cnt <= bit_cnt + 1'b1;
            end
          end
          ST_RIGHT: begin
            if (lr_change) begin
              if (bit_cnt == CNT_FULL) begin
                state   <= ST_LEFT;
                bit_cnt <= '0;
              end else begin
                frame_err <= 1'b1;
                state     <= ST_IDLE;
              end
            end else if (bit_cnt != CNT_FULL) begin
              right_sr <= right_next;
              bit_cnt  <= bit_cnt + 1'b1;
            end
          end
          default: state <= ST_IDLE;
        endcase
      end
    end
  end

endmodule

// File: tb/tb_i2s_adc_receiver.sv
// Bench for i2s_adc_receiver: drives an I2S master stream at clk/12 and checks each
// delivered stereo pair against a queue of expected frames.
module tb_i2s_adc_receiver;
  import i2s_adc_receiver_pkg::*;

  localparam int DW        = 16;
  localparam int SS        = 2;
  localparam int HALF_BITS = 32;
  localparam int BCLK_HALF = 6;

  logic          clk       = 1'b0;
  logic          reset_n   = 1'b0;
  logic          bclk      = 1'b1;
  logic          adclrck   = 1'b0;
  logic          adcdat    = 1'b0;
  logic          out_ready = 1'b0;
  logic [DW-1:0] left_out;
  logic [DW-1:0] right_out;
  logic          out_valid;
  logic          overrun;
  logic          frame_err;
  rx_state_t     dbg_state;

  int total    = 0;
  int bad      = 0;
  int ovr_cnt  = 0;
  int ferr_cnt = 0;
  int cyc      = 0;
  int t_lsb    = 0;
  logic prev_valid = 1'b0;
  logic [2*DW-1:0] exp_q[$];

  i2s_adc_receiver #(.DATA_WIDTH(DW), .SYNC_STAGES(SS)) dut (
    .clk       (clk),
    .reset_n   (reset_n),
    .bclk      (bclk),
    .adclrck   (adclrck),
    .adcdat    (adcdat),
    .left_out  (left_out),
    .right_out (right_out),
    .out_valid (out_valid),
    .out_ready (out_ready),
    .overrun   (overrun),
    .frame_err (frame_err),
    .dbg_state (dbg_state)
  );

  // clock / reset
  always #5 clk = ~clk;
  always @(posedge clk) cyc++;

  task automatic check_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
    total++;
    if (got !== exp) begin
      bad++;
      $display("FAIL %s: got=%h expected=%h (t=%0t)", tag, got, exp, $time);
    end
  endtask

  // monitor / scoreboard: sampled 1 time unit after the falling edge
  always @(negedge clk) begin
    logic [2*DW-1:0] exp_pair;
    #1;
    if (!reset_n) begin
      prev_valid = 1'b0;
    end else begin
      if (overrun)   ovr_cnt++;
      if (frame_err) ferr_cnt++;
      if (out_valid && !prev_valid) check_eq("latency", 32'(cyc - t_lsb), 32'(SS + 1));
      if (out_valid && out_ready) begin
        if (exp_q.size() == 0) begin
          check_eq("exp_avail", 32'(exp_q.size()), 32'd1);
        end else begin
          exp_pair = exp_q.pop_front();
          check_eq("pair", {left_out, right_out}, exp_pair);
        end
      end
      prev_valid = out_valid;
    end
  end

  // driver tasks: data changes with bclk low, is sampled on the rising edge
  task automatic send_bit(input logic lr, input logic d, input bit is_lsb, input bit rdy_at_lsb);
    bclk = 1'b0; adclrck = lr; adcdat = d;
    repeat (BCLK_HALF) @(negedge clk);
    bclk = 1'b1;
    if (is_lsb) t_lsb = cyc;
    for (int i = 1; i <= BCLK_HALF; i++) begin
      @(negedge clk);
      if (is_lsb && rdy_at_lsb && i == SS) out_ready = 1'b1;
      if (is_lsb && rdy_at_lsb && i == SS + 1) begin
        #1;
        check_eq("sim_valid", 32'(out_valid), 32'd1);
      end
    end
  endtask

  task automatic send_half(input logic lr, input logic [DW-1:0] word, input int nbits, input bit rdy_at_lsb);
    for (int i = 0; i < nbits; i++) begin
      logic d;
      if (i >= 1 && i <= DW) d = word[DW-i];
      else                   d = 1'($urandom_range(0, 1));
      send_bit(lr, d, (lr == CH_RIGHT) && (i == DW), rdy_at_lsb);
    end
  endtask

  task automatic send_frame(input logic [DW-1:0] l, input logic [DW-1:0] r, input bit expect_out, input bit rdy_at_lsb);
    if (expect_out) exp_q.push_back({l, r});
    send_half(CH_LEFT, l, HALF_BITS, 1'b0);
    send_half(CH_RIGHT, r, HALF_BITS, rdy_at_lsb);
  endtask

  task automatic pulse_reset();
    reset_n = 1'b0;
    repeat (3) @(negedge clk);
    reset_n = 1'b1;
  endtask

  initial begin
    // reset state
    repeat (4) @(negedge clk);
    #1;
    check_eq("rst_valid", 32'(out_valid), 32'd0);
    check_eq("rst_left", 32'(left_out), 32'd0);
    check_eq("rst_right", 32'(right_out), 32'd0);
    check_eq("rst_ovr", 32'(overrun), 32'd0);
    check_eq("rst_ferr", 32'(frame_err), 32'd0);
    check_eq("rst_state", 32'(dbg_state), 32'(ST_IDLE));
    @(negedge clk);
    reset_n = 1'b1;

    // basic frame, consumer always ready
    out_ready = 1'b1;
    send_half(CH_RIGHT, 16'h0000, HALF_BITS, 1'b0);
    send_frame(16'h8001, 16'h7FFE, 1'b1, 1'b0);
    check_eq("t1_ferr", 32'(ferr_cnt), 32'd0);

    // back-to-back frames with out_ready tied high
    send_frame(16'h1234, 16'h5678, 1'b1, 1'b0);
    send_frame(16'hFFFF, 16'h0000, 1'b1, 1'b0);
    check_eq("t2_ovr", 32'(ovr_cnt), 32'd0);

    // consumer stalled: A held, B and C dropped
    out_ready = 1'b0;
    send_frame(16'hA1A1, 16'hA2A2, 1'b1, 1'b0);
    send_frame(16'hB1B1, 16'hB2B2, 1'b0, 1'b0);
    send_frame(16'hC1C1, 16'hC2C2, 1'b0, 1'b0);
    #1;
    check_eq("t3_hold_valid", 32'(out_valid), 32'd1);
    check_eq("t3_hold_pair", {left_out, right_out}, 32'hA1A1A2A2);
    check_eq("t3_ovr", 32'(ovr_cnt), 32'd2);
    @(negedge clk);
    out_ready = 1'b1;
    @(negedge clk);
    out_ready = 1'b0;
    #1;
    check_eq("t3_valid_drop", 32'(out_valid), 32'd0);

    // consume of D in the same clk that E commits
    send_frame(16'hD1D1, 16'hD2D2, 1'b1, 1'b0);
    send_frame(16'hE1E1, 16'hE2E2, 1'b1, 1'b1);
    check_eq("t4_ovr", 32'(ovr_cnt), 32'd2);

    // stream starts mid right channel after reset
    pulse_reset();
    out_ready = 1'b1;
    send_half(CH_RIGHT, 16'hDEAD, 20, 1'b0);
    send_frame(16'h1111, 16'h2222, 1'b1, 1'b0);

    // truncated left half, then a good frame
    send_half(CH_LEFT, 16'h0BAD, 10, 1'b0);
    send_half(CH_RIGHT, 16'hBEEF, HALF_BITS, 1'b0);
    check_eq("t6_ferr", 32'(ferr_cnt), 32'd1);
    send_frame(16'h00AA, 16'h0055, 1'b1, 1'b0);

    // asynchronous reset mid right word with a pair held
    out_ready = 1'b0;
    send_frame(16'hCAFE, 16'hF00D, 1'b1, 1'b0);
    send_half(CH_LEFT, 16'h1357, HALF_BITS, 1'b0);
    send_half(CH_RIGHT, 16'h2468, 8, 1'b0);
    #1;
    check_eq("t7_pre_pair", {left_out, right_out}, 32'hCAFEF00D);
    #1;
    reset_n = 1'b0;
    #1;
    check_eq("t7_rst_valid", 32'(out_valid), 32'd0);
    check_eq("t7_rst_left", 32'(left_out), 32'd0);
    check_eq("t7_rst_right", 32'(right_out), 32'd0);
    check_eq("t7_rst_state", 32'(dbg_state), 32'(ST_IDLE));
    exp_q.delete();
    repeat (3) @(negedge clk);
    reset_n = 1'b1;
    out_ready = 1'b1;
    send_half(CH_RIGHT, 16'h2468, 24, 1'b0);
    send_frame(16'h4321, 16'h8765, 1'b1, 1'b0);

    // drain
    repeat (20) @(negedge clk);
    #2;
    check_eq("q_drain", 32'(exp_q.size()), 32'd0);
    check_eq("ovr_total", 32'(ovr_cnt), 32'd2);
    check_eq("ferr_total", 32'(ferr_cnt), 32'd1);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
